// File: rtl/router_pkt_tx.sv
// router_pkt_tx: stages payload bytes and sends one router packet per start (header, payload, parity).
// Latency: the header appears one cycle after an accepted start, and done follows 1+len+1+GAP_CYCLES cycles after start.
// Backpressure: router busy holds the presented byte; wr_ready is low while a packet is in flight or the buffer is full.
//
// Ports:
//   clock, resetn          rising-edge clock and synchronous active-low reset
//   wr_en/wr_data/wr_ready payload staging; count is the number of staged bytes (max 63)
//   start/dest_addr        launch request; bad_start pulses when a request is rejected
//   pkt_valid/data_out     registered byte stream to the router; busy and err come from the router
//   tx_busy/done/tx_err    packet in flight, end-of-gap pulse, and the router error seen during the gap
module router_pkt_tx #(
    parameter int GAP_CYCLES = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic [5:0] count,
    input  logic       start,
    input  logic [1:0] dest_addr,
    output logic       bad_start,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    input  logic       busy,
    input  logic       err,
    output logic       tx_busy,
    output logic       done,
    output logic       tx_err
);

    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;

    state_t     state, state_nx;
    logic [7:0] buffer [0:62];
    logic [5:0] len_q, len_nx;
    logic [5:0] rptr, rptr_nx;
    logic [1:0] addr_q, addr_nx;
    logic [7:0] parity, parity_nx;
    logic [3:0] gap_cnt, gap_nx;
    logic       err_seen, err_seen_nx;
    logic       tx_err_nx, done_nx, bad_start_nx, clr_count;
    logic       pkt_valid_nx;
    logic [7:0] data_out_nx;
    logic       wr_fire;

    // The write pointer always equals count, so count addresses the buffer directly.
    assign wr_ready = (state == IDLE) && !start && (count != 6'd63);
    assign wr_fire  = wr_en && wr_ready;
    assign tx_busy  = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        len_nx       = len_q;
        addr_nx      = addr_q;
        rptr_nx      = rptr;
        parity_nx    = parity;
        gap_nx       = gap_cnt;
        err_seen_nx  = err_seen;
        tx_err_nx    = tx_err;
        done_nx      = 1'b0;
        bad_start_nx = 1'b0;
        clr_count    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count == 6'd0 || dest_addr == 2'b11) begin
                        bad_start_nx = 1'b1;
                    end else begin
                        state_nx    = HEADER;
                        len_nx      = count;
                        addr_nx     = dest_addr;
                        parity_nx   = 8'h00;
                        err_seen_nx = 1'b0;
                        tx_err_nx   = 1'b0;
                    end
                end
            end
            HEADER: begin
                if (!busy) begin
                    parity_nx = parity ^ {len_q, addr_q};
                    rptr_nx   = 6'd0;
                    state_nx  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    parity_nx = parity ^ buffer[rptr];
                    rptr_nx   = rptr + 6'd1;
                    if (rptr == len_q - 6'd1) state_nx = PARITY;
                end
            end
            PARITY: begin
                // The last idle cycle of the gap is the done cycle, spent back in IDLE,
                // so the GAP state itself lasts GAP_CYCLES-1 cycles.
                if (!busy) begin
                    state_nx = GAP;
                    gap_nx   = 4'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                if (err) err_seen_nx = 1'b1;
                gap_nx = gap_cnt - 4'd1;
                if (gap_cnt == 4'd1) begin
                    state_nx  = IDLE;
                    done_nx   = 1'b1;
                    tx_err_nx = err_seen | err;
                    clr_count = 1'b1;
                    rptr_nx   = 6'd0;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Outputs are computed from the next state and then registered, so busy never reaches them combinationally.
        pkt_valid_nx = (state_nx == HEADER) || (state_nx == PAYLOAD);
        case (state_nx)
            HEADER:  data_out_nx = {len_nx, addr_nx};
            PAYLOAD: data_out_nx = buffer[rptr_nx];
            PARITY:  data_out_nx = parity_nx;
            default: data_out_nx = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count     <= 6'd0;
            len_q     <= 6'd0;
            addr_q    <= 2'd0;
            rptr      <= 6'd0;
            parity    <= 8'h00;
            gap_cnt   <= 4'd0;
            err_seen  <= 1'b0;
            tx_err    <= 1'b0;
            done      <= 1'b0;
            bad_start <= 1'b0;
            pkt_valid <= 1'b0;
            data_out  <= 8'h00;
        end else begin
            len_q     <= len_nx;
            addr_q    <= addr_nx;
            rptr      <= rptr_nx;
            parity    <= parity_nx;
            gap_cnt   <= gap_nx;
            err_seen  <= err_seen_nx;
            tx_err    <= tx_err_nx;
            done      <= done_nx;
            bad_start <= bad_start_nx;
            pkt_valid <= pkt_valid_nx;
            data_out  <= data_out_nx;
            if (clr_count)    count <= 6'd0;
            else if (wr_fire) count <= count + 6'd1;
        end
    end

    // Buffer storage needs no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (wr_fire) buffer[count] <= wr_data;
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: randomized and directed checks of router_pkt_tx against a packet-level reference model.
// Latency: it expects the header one cycle after start and done GAP cycles after the parity transfer.
// Backpressure: it drives busy and err as the router would, either scripted or random.
module tb_router_pkt_tx;
    localparam int GAP = 3;

    logic       clock = 1'b0;
    logic       resetn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [5:0] count;
    logic       start;
    logic [1:0] dest_addr;
    logic       bad_start;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       busy;
    logic       err;
    logic       tx_busy;
    logic       done;
    logic       tx_err;

    int vectors = 0;
    int miscompares = 0;
    int model_cnt = 0;

    router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
        .clock(clock), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
        .count(count), .start(start), .dest_addr(dest_addr), .bad_start(bad_start),
        .pkt_valid(pkt_valid), .data_out(data_out), .busy(busy), .err(err),
        .tx_busy(tx_busy), .done(done), .tx_err(tx_err)
    );

    always #5 clock = ~clock;

    // Stage bytes; the model count saturates at 63 and extra writes are dropped.
    task automatic write_bytes(input logic [7:0] q[$]);
        foreach (q[i]) begin
            vectors++;
            if (wr_ready !== (model_cnt < 63)) begin
                miscompares++;
                $display("FAIL wr_ready: got %b want %b (byte %0d)", wr_ready, model_cnt < 63, i);
            end
            wr_en = 1'b1;
            wr_data = q[i];
            if (model_cnt < 63) model_cnt++;
            @(negedge clock);
        end
        wr_en = 1'b0;
        vectors++;
        if (count !== 6'(model_cnt)) begin
            miscompares++;
            $display("FAIL count_after_write: got %0d want %0d", count, model_cnt);
        end
    endtask

    // bmode: 0 = never busy, 1 = random busy, 2 = scripted stalls (header held 2 cycles, second payload byte held 1)
    task automatic tx_pkt(input logic [7:0] pay[$], input logic [1:0] addr, input int bmode,
                          input bit raise_err, input bit poke_start);
        logic [7:0] exp[$];
        logic [7:0] par;
        logic [5:0] l6;
        int n, k, c, g;
        bit finished, b, poked;
        n = pay.size();
        l6 = 6'(n);
        exp.push_back({l6, addr});
        par = {l6, addr};
        foreach (pay[i]) begin
            exp.push_back(pay[i]);
            par = par ^ pay[i];
        end
        exp.push_back(par);
        start = 1'b1;
        dest_addr = addr;
        @(negedge clock);
        start = 1'b0;
        k = 0; c = 1; g = 0; finished = 1'b0; poked = 1'b0;
        while (!finished && c < 400) begin
            start = 1'b0;
            if (k <= n + 1) begin
                vectors++;
                if (pkt_valid !== (k <= n) || data_out !== exp[k]) begin
                    miscompares++;
                    $display("FAIL stream[%0d] cyc %0d: got v=%b d=%h want v=%b d=%h",
                             k, c, pkt_valid, data_out, k <= n, exp[k]);
                end
                vectors++;
                if (tx_busy !== 1'b1 || done !== 1'b0 || bad_start !== 1'b0) begin
                    miscompares++;
                    $display("FAIL inflight_flags cyc %0d: got tx_busy=%b done=%b bad_start=%b want 1 0 0",
                             c, tx_busy, done, bad_start);
                end
                if (c == 1) begin
                    vectors++;
                    if (tx_err !== 1'b0) begin
                        miscompares++;
                        $display("FAIL tx_err_clear_on_start: got %b want 0", tx_err);
                    end
                end
                case (bmode)
                    0:       b = 1'b0;
                    1:       b = ($urandom_range(0, 3) == 0);
                    default: b = (c == 1 || c == 2 || c == 5);
                endcase
                busy = b;
                if (poke_start && !poked && k >= 1 && k <= n) begin
                    start = 1'b1;
                    dest_addr = 2'd0;
                    poked = 1'b1;
                end
                if (!b) k++;
            end else begin
                g++;
                busy = $urandom_range(0, 1);
                err = raise_err && (g == 1);
                if (g < GAP) begin
                    vectors++;
                    if (done !== 1'b0 || pkt_valid !== 1'b0 || data_out !== 8'h00 || tx_busy !== 1'b1) begin
                        miscompares++;
                        $display("FAIL gap cyc %0d: got done=%b v=%b d=%h tx_busy=%b want 0 0 00 1",
                                 g, done, pkt_valid, data_out, tx_busy);
                    end
                end else begin
                    vectors++;
                    if (done !== 1'b1 || tx_err !== raise_err || count !== 6'd0 || tx_busy !== 1'b0 || pkt_valid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL done_cycle: got done=%b tx_err=%b count=%0d tx_busy=%b v=%b want 1 %b 0 0 0",
                                 done, tx_err, count, tx_busy, pkt_valid, raise_err);
                    end
                    finished = 1'b1;
                    model_cnt = 0;
                end
            end
            @(negedge clock);
            c++;
        end
        start = 1'b0;
        busy = 1'b0;
        err = 1'b0;
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL pkt_timeout: got no done within %0d cycles want done", c);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width: got %b want 0", done);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        model_cnt = 0;
        vectors++;
        if (pkt_valid !== 1'b0 || data_out !== 8'h00 || done !== 1'b0 || tx_err !== 1'b0 || bad_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b d=%h done=%b tx_err=%b bad=%b want all 0",
                     pkt_valid, data_out, done, tx_err, bad_start);
        end
        vectors++;
        if (count !== 6'd0 || tx_busy !== 1'b0 || wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got count=%0d tx_busy=%b wr_ready=%b want 0 0 1", count, tx_busy, wr_ready);
        end
    endtask

    task automatic test_basic;
        logic [7:0] q[$];
        q = '{8'h11, 8'h22, 8'h33};
        write_bytes(q);
        tx_pkt(q, 2'd1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        logic [7:0] q[$];
        q = '{8'h11, 8'h22, 8'h33};
        write_bytes(q);
        tx_pkt(q, 2'd1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_rejects;
        logic [7:0] q1[$];
        logic [7:0] q4[$];
        start = 1'b1;
        dest_addr = 2'd1;
        @(negedge clock);
        start = 1'b0;
        vectors++;
        if (bad_start !== 1'b1 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reject_empty: got bad=%b tx_busy=%b want 1 0", bad_start, tx_busy);
        end
        @(negedge clock);
        vectors++;
        if (bad_start !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_start_width: got %b want 0", bad_start);
        end
        q1 = '{8'h5C};
        write_bytes(q1);
        start = 1'b1;
        dest_addr = 2'd3;
        @(negedge clock);
        start = 1'b0;
        vectors++;
        if (bad_start !== 1'b1 || count !== 6'd1 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reject_addr3: got bad=%b count=%0d tx_busy=%b want 1 1 0", bad_start, count, tx_busy);
        end
        @(negedge clock);
        tx_pkt(q1, 2'd0, 0, 1'b0, 1'b0);
        q4 = '{8'h01, 8'h80, 8'h7E, 8'hC3};
        write_bytes(q4);
        tx_pkt(q4, 2'd2, 0, 1'b0, 1'b1);
    endtask

    task automatic test_full;
        logic [7:0] q[$];
        for (int i = 0; i < 64; i++) q.push_back(8'hA5);
        write_bytes(q);
        vectors++;
        if (wr_ready !== 1'b0 || count !== 6'd63) begin
            miscompares++;
            $display("FAIL full_buffer: got wr_ready=%b count=%0d want 0 63", wr_ready, count);
        end
        void'(q.pop_back());
        tx_pkt(q, 2'd2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_err;
        logic [7:0] q[$];
        q = '{8'h3A, 8'h9F};
        write_bytes(q);
        tx_pkt(q, 2'd0, 1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (tx_err !== 1'b1) begin
                miscompares++;
                $display("FAIL tx_err_hold[%0d]: got %b want 1", i, tx_err);
            end
            @(negedge clock);
        end
        write_bytes(q);
        tx_pkt(q, 2'd1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        logic [7:0] q[$];
        logic [7:0] q1[$];
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
        write_bytes(q);
        start = 1'b1;
        dest_addr = 2'd1;
        busy = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if (pkt_valid !== 1'b1 || data_out !== q[1]) begin
            miscompares++;
            $display("FAIL pre_reset_byte: got v=%b d=%h want 1 %h", pkt_valid, data_out, q[1]);
        end
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        model_cnt = 0;
        vectors++;
        if (pkt_valid !== 1'b0 || data_out !== 8'h00 || count !== 6'd0 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got v=%b d=%h count=%0d tx_busy=%b want 0 00 0 0",
                     pkt_valid, data_out, count, tx_busy);
        end
        q1 = '{8'hE7};
        write_bytes(q1);
        tx_pkt(q1, 2'd2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        logic [7:0] q[$];
        for (int p = 0; p < 12; p++) begin
            q.delete();
            for (int i = 0; i < int'($urandom_range(1, 24)); i++) q.push_back(8'($urandom));
            write_bytes(q);
            tx_pkt(q, 2'($urandom_range(0, 2)), 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        resetn = 1'b0;
        wr_en = 1'b0;
        wr_data = 8'h00;
        start = 1'b0;
        dest_addr = 2'd0;
        busy = 1'b0;
        err = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_stall();
        test_rejects();
        test_full();
        test_err();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet source that drives the input side of the 1x3 router, i.e. the pkt_valid/data_in/busy/err interface.
- Payload bytes are staged into an internal 63-entry buffer. On start, the block serializes one packet: header {len[5:0],addr[1:0]}, then payload, then a parity byte.
- Honours router busy stalls and samples router err after the parity byte.
- Used as the host-side transmitter for system integration and as a reusable bench driver.

Parameters:
- GAP_CYCLES, 3, idle cycles after the parity byte before the next packet may start; err is sampled during this window. Legal range 2..15.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- wr_en  in  1  write one payload byte into the buffer
- wr_data  in  8  payload byte
- wr_ready  out  1  combinational: (state==IDLE) && !start && count<63
- count  out  6  bytes currently staged
- start  in  1  launch a packet from the staged bytes
- dest_addr  in  2  destination port, sampled on an accepted start
- bad_start  out  1  1-cycle pulse: start rejected
- pkt_valid  out  1  to router pkt_valid
- data_out  out  8  to router data_in
- busy  in  1  from router; 1 = do not advance
- err  in  1  from router parity error flag
- tx_busy  out  1  state != IDLE
- done  out  1  1-cycle pulse at end of the GAP window
- tx_err  out  1  err was seen during GAP; valid with done, held until the next accepted start

Behaviour:
- Reset (resetn=0 at a clock edge):
  - State IDLE; buffer pointers, count, parity accumulator and gap counter cleared.
  - Outputs pkt_valid=0, data_out=0x00, done=0, tx_err=0, bad_start=0.
  - Reset mid-packet aborts immediately with no trailing parity byte.
- Buffer:
  - Write occurs at an edge with wr_en && wr_ready; data goes to buffer[wptr], wptr++ and count++.
  - A write with wr_ready=0 is dropped silently.
  - count saturates at 63, because the header length field is 6 bits.
- Start acceptance (IDLE only):
  - Rejected when count==0 or dest_addr==2'b11: bad_start pulses next cycle, state stays IDLE, buffer is untouched.
  - Start outside IDLE is ignored with no bad_start.
  - A wr_en in the same cycle as start is dropped, since wr_ready is low.
- States:
  - IDLE
    - pkt_valid=0, data_out=0.
    - On a valid start: latch len=count and addr=dest_addr, clear the parity accumulator, go to HEADER.
  - HEADER (first cycle is the edge after start)
    - pkt_valid=1, data_out={len,addr}.
    - At an edge with busy==0: parity ^= header, rptr=0, go to PAYLOAD.
    - With busy==1: hold all outputs.
  - PAYLOAD
    - pkt_valid=1, data_out=buffer[rptr].
    - At an edge with busy==0: parity ^= byte, rptr++.
    - After transferring byte len-1, go to PARITY.
    - pkt_valid never drops mid-payload, because the router treats pkt_valid=0 as the parity byte.
  - PARITY
    - pkt_valid=0, data_out=parity accumulator (XOR of header and all payload bytes).
    - At an edge with busy==0: go to GAP and load the gap counter with GAP_CYCLES.
  - GAP
    - pkt_valid=0, data_out=0.
    - Any edge with err==1 sets the internal err_seen flag.
    - The counter decrements each cycle. When it reaches 0: done=1 for one cycle, tx_err=err_seen, count/wptr/rptr cleared, go to IDLE.
- Busy: a byte counts as transferred only at an edge where it is presented and busy==0. busy is ignored in IDLE and GAP.
- Latency: header appears 1 cycle after an accepted start. Minimum packet time with no stalls is 1+len+1+GAP_CYCLES cycles from start to done.
- Data registering: data_out and pkt_valid are registered; no combinational path from busy to outputs.
- Buffer reuse: the buffer cannot be reused to resend a packet; a new packet needs fresh writes.

Test Plan:
- Basic packet: write 0x11,0x22,0x33; start with dest_addr=1, busy=0 → data_out 0x0D,0x11,0x22,0x33 with pkt_valid=1; then 0x0D with pkt_valid=0; done at cycle 1+3+1+3 after start; tx_err=0; count=0.
- Stall: same packet, busy=1 for 2 cycles after the header appears, then again on the second payload byte → each byte held unchanged for the stall duration; no byte skipped or duplicated; parity still 0x0D.
- Rejects:
  - start with count=0 → bad_start pulse, tx_busy stays 0.
  - Write 1 byte, start with dest_addr=3 → bad_start pulse, count stays 1.
  - start during PAYLOAD → ignored.
- Full buffer: 64 writes of 0xA5 → count=63, wr_ready=0, 64th write dropped; start with dest_addr=2 → header 0xFE, 63×0xA5, parity 0xFE^0xA5=0x5B.
- Error report: router model raises err 1 cycle into GAP → tx_err=1 with done and held until the next start, where it is cleared; with no err → tx_err=0.
- Reset mid-payload: resetn=0 during byte 2 of 5 → next cycle pkt_valid=0, data_out=0, count=0, tx_busy=0; subsequent 1-byte packet transmits correctly.
